// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed 7-segment scan controller with dead-time blanking and frame-synchronous data swap
// Outputs are registered from next-state values so they line up with the cycle count they describe.
module seg_scan_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  lz_en,
  output logic [3:0]            nib,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick,
  output logic                  pend
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [IW-1:0]        idx, idx_n;
  logic [4*DIGITS-1:0]  disp, disp_n, shadow;
  logic                 slot_end, frame_end, ft_n, above;
  logic [3:0]           nib_n;
  logic [DIGITS-1:0]    an_n, lz_dark;

  always_comb begin
    slot_end  = (cnt == CW'(PRESCALE - 1));
    frame_end = slot_end && (idx == IW'(DIGITS - 1));

    cnt_n = slot_end ? '0 : cnt + 1'b1;
    idx_n = idx;
    if (slot_end)
      idx_n = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;

    disp_n = (frame_end && pend) ? shadow : disp;

    state_n = state;
    case (state)
      ST_BLANK: if (cnt_n == CW'(BLANK)) state_n = ST_SHOW;
      ST_SHOW:  if (cnt_n == '0)         state_n = ST_BLANK;
      default:                           state_n = ST_BLANK;
    endcase

    ft_n = (cnt_n == CW'(PRESCALE - 1)) && (idx_n == IW'(DIGITS - 1));

    // A digit is dark when it and everything above it are zero; digit 0 always shows.
    above   = 1'b1;
    lz_dark = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      above      = above && (disp_n[4*k +: 4] == 4'd0);
      lz_dark[k] = lz_en && above && (k != 0);
    end

    nib_n = nib;
    if (cnt_n == '0) begin
      for (int k = 0; k < DIGITS; k++)
        if (idx_n == IW'(k)) nib_n = disp_n[4*k +: 4];
    end

    an_n = '1;
    if (state_n == ST_SHOW) begin
      for (int k = 0; k < DIGITS; k++)
        if ((idx_n == IW'(k)) && !lz_dark[k]) an_n[k] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_BLANK;
      cnt        <= '0;
      idx        <= '0;
      disp       <= '0;
      shadow     <= '0;
      pend       <= 1'b0;
      nib        <= 4'd0;
      an         <= '1;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      disp       <= disp_n;
      nib        <= nib_n;
      an         <= an_n;
      frame_tick <= ft_n;
      // A load on the boundary edge keeps pend set; the swap above used the old shadow.
      if (load) begin
        shadow <= data;
        pend   <= 1'b1;
      end else if (frame_end) begin
        pend   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

  localparam int D = 4;
  localparam int P = 8;
  localparam int B = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic [15:0]   data = '0;
  logic          lz_en = 1'b0;
  logic [3:0]    nib;
  logic [3:0]    an;
  logic          frame_tick;
  logic          pend;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  seg_scan_ctrl #(.DIGITS(D), .PRESCALE(P), .BLANK(B)) dut (
    .clk(clk), .rst(rst), .load(load), .data(data), .lz_en(lz_en),
    .nib(nib), .an(an), .frame_tick(frame_tick), .pend(pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic do_load(input logic [15:0] d);
    load = 1'b1;
    data = d;
    step();
    load = 1'b0;
  endtask

  // Checks one full frame starting at the current cycle, which must be slot 0 / cnt 0.
  task automatic run_frame(input logic [15:0] d, input logic lz, input string tag);
    int slot, pos;
    logic [3:0] dig, an_e;
    logic [15:0] upper;
    logic dark;
    for (int i = 0; i < D * P; i++) begin
      slot  = i / P;
      pos   = i % P;
      upper = d >> (4 * slot);
      dig   = upper[3:0];
      dark  = lz && (slot != 0) && (upper == 16'd0);
      an_e  = (pos < B || dark) ? 4'hF : ~(4'b0001 << slot);
      chk($sformatf("%s an c%0d", tag, cyc), {28'd0, an}, {28'd0, an_e});
      chk($sformatf("%s nib c%0d", tag, cyc), {28'd0, nib}, {28'd0, dig});
      chk($sformatf("%s tick c%0d", tag, cyc), {31'd0, frame_tick}, {31'd0, (i == D * P - 1)});
      step();
    end
  endtask

  initial begin
    // Idle scan after reset, no data ever loaded
    reset_dut();
    chk("rst pend", {31'd0, pend}, 32'd0);
    chk("rst an", {28'd0, an}, 32'hF);
    run_frame(16'h0000, 1'b0, "idle");

    // Single load mid-frame, applied at the boundary
    reset_dut();
    go_to(5);
    do_load(16'h1234);
    chk("ld pend c6", {31'd0, pend}, 32'd1);
    go_to(31);
    chk("ld pend c31", {31'd0, pend}, 32'd1);
    step();
    chk("ld pend c32", {31'd0, pend}, 32'd0);
    run_frame(16'h1234, 1'b0, "f1234");

    // Last of two loads wins; leading-zero blanking
    reset_dut();
    lz_en = 1'b1;
    go_to(10);
    do_load(16'hAAAA);
    go_to(20);
    do_load(16'h00C5);
    go_to(32);
    run_frame(16'h00C5, 1'b1, "lz00c5");
    do_load(16'h0000);
    chk("lz pend", {31'd0, pend}, 32'd1);
    go_to(96);
    run_frame(16'h0000, 1'b1, "lz0000");
    lz_en = 1'b0;

    // Load on the boundary cycle while another load is pending
    reset_dut();
    go_to(3);
    do_load(16'h1111);
    go_to(31);
    do_load(16'h9876);
    chk("bnd pend c32", {31'd0, pend}, 32'd1);
    run_frame(16'h1111, 1'b0, "b1111");
    chk("bnd pend c64", {31'd0, pend}, 32'd0);
    run_frame(16'h9876, 1'b0, "b9876");

    // Asynchronous reset mid-slot
    reset_dut();
    go_to(3);
    do_load(16'h1234);
    go_to(40);
    do_load(16'h5555);
    go_to(45);
    chk("pre an", {28'd0, an}, 32'hD);
    chk("pre nib", {28'd0, nib}, 32'h3);
    chk("pre pend", {31'd0, pend}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst an", {28'd0, an}, 32'hF);
    chk("arst nib", {28'd0, nib}, 32'h0);
    chk("arst pend", {31'd0, pend}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    run_frame(16'h0000, 1'b0, "post");
    chk("post pend", {31'd0, pend}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a multi-digit common-cathode 7-segment display. It holds one 4-bit value per digit and presents one nibble at a time to the shared downstream 4-bit-to-7-segment decoder. It drives the active-low digit-enable lines and inserts a dead-time blank between digits to suppress ghosting. New display data is accepted through a load strobe and applied only at a frame boundary, so the display never tears.

Parameters:
DIGITS, 4, number of digits scanned; 2..8.
PRESCALE, 50000, clk cycles per digit slot (blank plus show); must be greater than BLANK.
BLANK, 16, dead-time cycles at the start of each slot with all digits off; must be at least 1.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous active-high reset.
load  input  1  one-cycle strobe; captures data into the shadow register.
data  input  4*DIGITS  digit values; nibble k (bits 4k+3:4k) is digit k; digit 0 is least significant.
lz_en  input  1  leading-zero blanking enable; sampled every cycle.
nib  output  4  nibble for the current digit, to the segment decoder.
an  output  DIGITS  digit cathode enables, active-low (0 = digit lit).
frame_tick  output  1  one-cycle pulse on the last cycle of each full frame.
pend  output  1  shadow data is waiting to be applied.

Behaviour:
- Interface: one clock (clk); reset (rst) is asynchronous and active-high. All outputs are registered.
- Reset values: an = all 1s, nib = 0, frame_tick = 0, pend = 0. Internal state: disp = 0, shadow = 0, idx = 0, cnt = 0, state = BLANK.
- Reset asserted mid-frame forces the reset values immediately. Any pending load is discarded.
- cnt counts 0..PRESCALE-1 each slot, then wraps to 0. On wrap, idx advances by 1, wrapping from DIGITS-1 to 0.
- Counter width is clog2(PRESCALE). idx width is clog2(DIGITS), minimum 1.
- Scan order is digit 0 first, then ascending.
- BLANK state (cnt 0..BLANK-1):
  - an = all 1s.
  - nib is loaded with disp[idx] on the first cycle of this state and then held stable, giving the decoder settle time.
- SHOW state (cnt BLANK..PRESCALE-1):
  - an[idx] = 0; all other bits are 1.
  - nib stays at disp[idx].
- Transitions: BLANK -> SHOW when cnt reaches BLANK. SHOW -> BLANK on slot wrap.
- Leading-zero blanking: with lz_en = 1, digit k stays dark (an[k] = 1 throughout its SHOW) when disp[k] and every digit above k are all 0.
  - Digit 0 is never blanked, so a value of all zeros still shows a single "0".
  - With lz_en = 0, all digits are shown.
- Load handshake:
  - On a clk edge with load = 1: shadow <= data and pend <= 1.
  - Repeated loads before a frame boundary overwrite shadow; only the last one is applied.
- Frame boundary is the cycle where idx = DIGITS-1 and cnt = PRESCALE-1.
  - frame_tick = 1 during that cycle.
  - At that edge, if pend = 1: disp <= shadow and pend <= 0.
- Load coinciding with the frame boundary:
  - The swap uses the old shadow.
  - shadow takes the new data and pend remains 1; the new data is applied at the next boundary.
- No load ever: disp stays at its reset value of 0 and the display scans continuously.

Test Plan:
1. Use DIGITS=4, PRESCALE=8, BLANK=2 for all scenarios.
2. Reset release -> an = 4'b1111 for cycles 0-1; an = 4'b1110 for cycles 2-7; an = 4'b1101 for cycles 10-15; frame_tick high in cycle 31; nib = 0 throughout.
3. load with data = 16'h1234 in cycle 5 -> pend = 1 until the cycle-31 edge, then pend = 0. In the next frame nib = 4, 3, 2, 1 during slots 0-3, with each digit lit for 6 cycles after 2 blank cycles.
4. Loads of 16'hAAAA in cycle 10 and 16'h00C5 in cycle 20 -> the next frame shows 5, C, 0, 0. With lz_en = 1, an[3] and an[2] stay at 1 for the whole frame. Set data = 16'h0000 with lz_en = 1 -> only an[0] pulses low, and nib = 0.
5. load with 16'h9876 exactly in cycle 31, while a prior 16'h1111 is pending -> the frame starting at cycle 32 shows 1111 and pend stays 1; the frame starting at cycle 64 shows 9876 and pend = 0.
6. rst asserted asynchronously in cycle 13 -> an = 1111, nib = 0 and pend = 0 immediately, without waiting for a clock. After release, the scan restarts at idx = 0, cnt = 0, and disp = 0.
